// File: rtl/mul_pkg.sv
// Shared sizing, state encoding and step-datapath bundle for the h6 sequential multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_ITER  = 16;
  localparam int CNT_W     = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Working registers that one iteration reads and rewrites.
  typedef struct packed {
    logic [MUL_WIDTH-1:0] a;
    logic [MUL_WIDTH-1:0] q;
    logic                 qm1;
    logic                 c;
  } mul_regs_t;

  function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(MUL_ITER - 1);
  endfunction

endpackage

// File: rtl/h6_mul_step.sv
// One combinational multiply iteration: conditional add/subtract of M into A, then a
// one-bit right shift of the {C/A, Q, Q_-1} chain (logical unsigned, arithmetic Booth).
module h6_mul_step
  import mul_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a_i,
  input  logic [MUL_WIDTH-1:0] q_i,
  input  logic                 qm1_i,
  input  logic                 c_i,
  input  logic [MUL_WIDTH-1:0] m_i,
  input  logic                 signed_mode_i,
  output logic [MUL_WIDTH-1:0] a_o,
  output logic [MUL_WIDTH-1:0] q_o,
  output logic                 qm1_o,
  output logic                 c_o
);

  logic [MUL_WIDTH:0] acc;

  always_comb begin
    acc   = '0;
    a_o   = a_i;
    q_o   = q_i;
    qm1_o = qm1_i;
    c_o   = 1'b0;
    if (signed_mode_i) begin
      // 17-bit sign-extended accumulator keeps A -/+ M exact even for M = -32768.
      unique case ({q_i[0], qm1_i})
        2'b01:   acc = {a_i[MUL_WIDTH-1], a_i} + {m_i[MUL_WIDTH-1], m_i};
        2'b10:   acc = {a_i[MUL_WIDTH-1], a_i} - {m_i[MUL_WIDTH-1], m_i};
        default: acc = {a_i[MUL_WIDTH-1], a_i};
      endcase
      qm1_o = q_i[0];
    end else begin
      // C is always zero entering an iteration, so {C,A} is just the zero-extended A.
      acc = {c_i, a_i} + (q_i[0] ? {1'b0, m_i} : '0);
    end
    a_o = acc[MUL_WIDTH:1];
    q_o = {acc[0], q_i[MUL_WIDTH-1:1]};
  end

endmodule

// File: rtl/h6_multiplier.sv
// 16x16 sequential multiplier (unsigned shift-add or signed Booth radix-2), one iteration
// per CALC cycle; a_out/q_out expose the live A/Q registers and hold the product afterwards.
module h6_multiplier
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [MUL_WIDTH-1:0] multiplicand,
  input  logic [MUL_WIDTH-1:0] multiplier,
  output logic [MUL_WIDTH-1:0] a_out,
  output logic [MUL_WIDTH-1:0] q_out,
  output logic                 busy,
  output logic                 done
);

  mul_state_e           state_q, state_d;
  mul_regs_t            regs_q, regs_d;
  mul_regs_t            step;
  logic [MUL_WIDTH-1:0] m_q, m_d;
  logic                 sgn_q, sgn_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  h6_mul_step u_step (
    .a_i           (regs_q.a),
    .q_i           (regs_q.q),
    .qm1_i         (regs_q.qm1),
    .c_i           (regs_q.c),
    .m_i           (m_q),
    .signed_mode_i (sgn_q),
    .a_o           (step.a),
    .q_o           (step.q),
    .qm1_o         (step.qm1),
    .c_o           (step.c)
  );

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d        = multiplicand;
          sgn_d      = signed_mode;
          regs_d.a   = '0;
          regs_d.q   = multiplier;
          regs_d.qm1 = 1'b0;
          regs_d.c   = 1'b0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        regs_d = step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (is_last_iter(cnt_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      regs_q  <= '0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_out = regs_q.a;
  assign q_out = regs_q.q;
  assign busy  = (state_q == CALC);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_h6_multiplier.sv
// Directed bench for h6_multiplier: arithmetic reference model with expected-product queue,
// per-cycle compare of busy/done/product, and literal checks on hand-computed vectors.
module tb_h6_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [15:0] a_out;
  logic [15:0] q_out;
  logic        busy;
  logic        done;

  h6_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .a_out        (a_out),
    .q_out        (q_out),
    .busy         (busy),
    .done         (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_prod = '0;
  int          m_cyc = 0;   // 0 idle, 1..16 calculating, 17 done pulse

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] m, input logic [15:0] q,
                                           input logic s);
    longint pm;
    longint pq;
    if (s) begin
      pm = longint'($signed(m));
      pq = longint'($signed(q));
    end else begin
      pm = longint'(m);
      pq = longint'(q);
    end
    return 32'(pm * pq);
  endfunction

  // Inputs change 1 time unit after a falling edge, so at each falling edge they equal
  // what the DUT sampled at the preceding rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0;
      exp_q.delete();
      last_prod = '0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_cyc = 1;
        exp_q.push_back(ref_prod(multiplicand, multiplier, signed_mode));
      end
    end else if (m_cyc == 17) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
    end

    check("busy", {31'b0, busy}, {31'b0, (m_cyc >= 1 && m_cyc <= 16)});
    check("done", {31'b0, done}, {31'b0, (m_cyc == 17)});
    if (m_cyc == 17) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        last_prod = exp_q.pop_front();
      end
    end
    if (m_cyc == 0 || m_cyc == 17) begin
      check("product", {a_out, q_out}, last_prod);
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 unit after a falling edge. The start-sampling edge is counted as edge 1.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input logic s,
                        input logic [15:0] ea, input logic [15:0] eq, input string tag);
    int edge_idx = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    multiplicand = m;
    multiplier   = q;
    signed_mode  = s;
    start        = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      edge_idx++;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
      end else if (edge_idx == 1) begin
        #1;
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        signed_mode  = ~s;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_done_edge"}, 32'(edge_idx), 32'd17);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
      check({tag, "_a_out"}, {16'b0, a_out}, {16'b0, ea});
      check({tag, "_q_out"}, {16'b0, q_out}, {16'b0, eq});
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    #1 rst = 1'b1;
    #1;
    check("rst_a_out", {16'b0, a_out}, 32'd0);
    check("rst_q_out", {16'b0, q_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Start raised in the same cycle reset drops: accepted at the first edge.
    run_op(16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F, "u_3x5");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, "u_ffff_sq");
    run_op(16'h1234, 16'h00FF, 1'b0, 16'h0012, 16'h21CC, "u_1234x00ff");
    run_op(16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, "s_m1x1");
    run_op(16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000, "s_min_sq");
    run_op(16'h0003, 16'hFFFB, 1'b1, 16'hFFFF, 16'hFFF1, "s_3xm5");
    run_op(16'h7FFF, 16'h8000, 1'b1, 16'hC000, 16'h8000, "s_max_x_min");

    // Start held high: accepts at edges 1 and 19, operands swapped mid-CALC of the first.
    multiplicand = 16'h0003;
    multiplier   = 16'h0005;
    signed_mode  = 1'b0;
    start        = 1'b1;
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin
          check("stress_done1_edge", 32'(i), 32'd17);
          check("stress_q1", {16'b0, q_out}, 32'h0000_000F);
        end else if (dones == 2) begin
          check("stress_done2_edge", 32'(i), 32'd35);
        end
      end
      if (i == 8) begin
        #1;
        multiplicand = 16'h0007;
        multiplier   = 16'h0009;
      end
      if (i == 20) begin
        #1;
        start = 1'b0;
      end
    end
    check("stress_done_count", 32'(dones), 32'd2);
    check("stress_a2", {16'b0, a_out}, 32'd0);
    check("stress_q2", {16'b0, q_out}, 32'h0000_003F);
    #1;

    // Reset after 8 iterations aborts the operation.
    multiplicand = 16'h00FF;
    multiplier   = 16'h00FF;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_a_out", {16'b0, a_out}, 32'd0);
    check("abort_q_out", {16'b0, q_out}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    #1;
    run_op(16'h0007, 16'h0009, 1'b0, 16'h0000, 16'h003F, "u_7x9_after_rst");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/h6_multiplier.md
H6_MULTIPLIER -- requirements
Module: h6_multiplier

Interface
REQ-001 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-002 SHALL have the ports below (clock and reset first):
- clk  input  1  rising-edge clock
- rst  input  1  async active-high reset
- start  input  1  request multiply; sampled only in IDLE
- signed_mode  input  1  0 = unsigned shift-add, 1 = two's-complement Booth radix-2
- multiplicand  input  16  M operand; sampled with start
- multiplier  input  16  Q operand; sampled with start
- a_out  output  16  product bits [31:16]; feeds H6_a_out of PSW logic
- q_out  output  16  product bits [15:0]; feeds H6_q_out of PSW logic
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse in DONE

Function
REQ-003 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-004 In IDLE with start=1 at an edge, SHALL latch M, signed_mode and Q, clear A, C and Q_-1, clear the 4-bit counter, and enter CALC.
REQ-005 SHALL perform exactly one iteration per CALC cycle, 16 iterations total; the counter SHALL increment each cycle, and the edge at count=15 SHALL enter DONE.
REQ-006 Unsigned iteration SHALL compute {C,A} = A + (Q[0] ? M : 0), then shift {C,A,Q} right logically by 1.
REQ-007 Signed iteration SHALL select on {Q[0],Q_-1}: 01 -> A+M, 10 -> A-M, 00 or 11 -> A; it SHALL then arithmetic-shift {A,Q,Q_-1} right by 1.
REQ-008 Signed arithmetic SHALL use a 17-bit sign-extended accumulator so that M = 0x8000 yields an exact 32-bit product.
REQ-009 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-010 done SHALL rise 17 edges after the edge that sampled start.
REQ-011 start SHALL be ignored in CALC and DONE; no queuing.
REQ-012 a_out and q_out SHALL show the live A and Q registers; after DONE they SHALL hold the product until the next accepted start.
REQ-013 Operand changes after the start edge SHALL have no effect on the result.
REQ-014 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.

Reset
REQ-015 rst=1 SHALL force, asynchronously, state=IDLE, A=Q=M=0, C=Q_-1=0, counter=0, a_out=q_out=0x0000, busy=0 and done=0.
REQ-016 Reset during CALC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-017 The first start SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-018 Package mul_pkg SHALL hold MUL_WIDTH=16, MUL_ITER=16 and the state enum type (IDLE, CALC, DONE).
REQ-019 SHALL instantiate one combinational sub-module, h6_mul_step, which computes one iteration (add/sub select plus shift) from A, Q, Q_-1, C, M and signed_mode; FSM and registers remain in h6_multiplier.

Verification
REQ-020 Unsigned: M=0x0003, Q=0x0005 -> done at edge 17, a_out=0x0000, q_out=0x000F, busy high for 16 cycles.
REQ-021 Unsigned: M=0xFFFF, Q=0xFFFF -> a_out=0xFFFE, q_out=0x0001.
REQ-022 Signed: M=0xFFFF (-1), Q=0x0001 -> a_out=0xFFFF, q_out=0xFFFF; then M=0x8000, Q=0x8000 -> a_out=0x4000, q_out=0x0000.
REQ-023 Start stress: start held high through a whole operation -> exactly one done pulse per accepted start, with the next start accepted only in IDLE (one idle cycle between operations); operands changed mid-CALC do not alter the result.
REQ-024 Reset: rst pulsed mid-CALC (after 8 iterations) -> immediate busy=0, a_out=q_out=0, no done; a following multiply of 7 x 9 returns q_out=0x003F.
